gate_stream_sequencer: RTL and testbench

//  Buffers the host gate stream and sequences the stabilizer control unit one circuit at a time.

---
 rtl/qcm_gate_pkg.sv | 36 +++
 rtl/gate_fifo.sv | 55 +++++
 rtl/gate_stream_sequencer.sv | 154 +++++++++++++++
 tb/tb_gate_stream_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcm_gate_pkg.sv
// ============================================================================
// qcm_gate_pkg : gate encodings, descriptor layout and sequencer state enum
// Rev 1.0
// ============================================================================
`default_nettype none

package qcm_gate_pkg;

  localparam logic [1:0] GT_H    = 2'd0;
  localparam logic [1:0] GT_S    = 2'd1;
  localparam logic [1:0] GT_CNOT = 2'd2;
  localparam logic [1:0] GT_MEAS = 2'd3;

  function automatic int qw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_NUM_QUBIT = 4;
  localparam int DEFAULT_QW        = qw_of(DEFAULT_NUM_QUBIT);

  typedef struct packed {
    logic                  last;
    logic [1:0]            gtype;
    logic [DEFAULT_QW-1:0] q1;
    logic [DEFAULT_QW-1:0] q2;
  } gate_desc_t;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_RUN     = 2'd1,
    SEQ_READOUT = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/gate_fifo.sv
// ============================================================================
// gate_fifo : show-ahead FIFO for gate descriptors; head reads as 0 when empty
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_fifo #(
  parameter  int WIDTH = 7,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gate_stream_sequencer.sv
// ============================================================================
// gate_stream_sequencer : buffers host gates and sequences the control unit
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_stream_sequencer
  import qcm_gate_pkg::*;
#(
  parameter  int num_qubit  = 4,
  parameter  int FIFO_DEPTH = 16,
  localparam int QW         = qw_of(num_qubit),
  localparam int DW         = 3 + 2 * QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gate_valid,
  output logic          gate_ready,
  input  logic [DW-1:0] gate_data,
  input  logic          ld_gate_info,
  input  logic          done_readout,
  output logic          start,
  output logic [1:0]    gate_type,
  output logic [QW-1:0] qubit_pos1,
  output logic [QW-1:0] qubit_pos2,
  output logic          gate_end,
  output logic          literal_phase_readout,
  output logic          busy,
  output logic          circuit_done,
  output logic          underrun_err,
  output logic [15:0]   gates_issued
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic          last;
    logic [1:0]    gtype;
    logic [QW-1:0] q1;
    logic [QW-1:0] q2;
  } desc_t;

  seq_state_t    state;
  seq_state_t    state_nxt;
  desc_t         head;
  logic [DW-1:0] head_raw;
  logic [CW-1:0] count;
  logic [CW-1:0] last_cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          go;
  logic          ld_run;
  logic          end_now;
  logic          underrun_now;
  logic          end_pend;
  logic          start_q;
  logic          done_q;
  logic          underrun_q;
  logic [15:0]   issued_q;

  gate_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (gate_data),
    .rdata (head_raw),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head         = desc_t'(head_raw);
  assign gate_ready   = !full;
  assign push         = gate_valid && !full;
  assign ld_run       = (state == SEQ_RUN) && ld_gate_info;
  assign pop          = ld_run && !empty && !end_pend;
  assign end_now      = ld_run && (end_pend || empty);
  assign underrun_now = ld_run && empty && !end_pend;
  assign go           = (last_cnt != '0) || (count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEQ_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE:    if (go)           state_nxt = SEQ_RUN;
      SEQ_RUN:     if (end_now)      state_nxt = SEQ_READOUT;
      SEQ_READOUT: if (done_readout) state_nxt = SEQ_IDLE;
      default:                       state_nxt = SEQ_IDLE;
    endcase
  end

  // Complete circuits buffered in the FIFO; drives the IDLE->RUN decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_cnt <= '0;
    else      last_cnt <= last_cnt + CW'(push && gate_data[DW-1]) - CW'(pop && head.last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_pend   <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      issued_q   <= '0;
    end else begin
      start_q <= (state == SEQ_IDLE) && go;
      done_q  <= (state == SEQ_READOUT) && done_readout;
      if ((state == SEQ_IDLE) && go) begin
        issued_q   <= '0;
        underrun_q <= 1'b0;
        end_pend   <= 1'b0;
      end
      if (pop) begin
        end_pend <= head.last;
        if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      end else if (end_now) begin
        end_pend <= 1'b0;
      end
      if (underrun_now) underrun_q <= 1'b1;
    end
  end

  always_comb begin
    start                 = start_q;
    circuit_done          = done_q;
    underrun_err          = underrun_q;
    gates_issued          = issued_q;
    busy                  = (state != SEQ_IDLE);
    literal_phase_readout = (state == SEQ_READOUT);
    gate_end              = end_now || (state == SEQ_READOUT);
    gate_type             = head.gtype;
    qubit_pos1            = head.q1;
    qubit_pos2            = head.q2;
    // The END pseudo-gate overrides the head only in the cycle it is loaded
    if (end_now) begin
      gate_type  = GT_H;
      qubit_pos1 = '0;
      qubit_pos2 = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_stream_sequencer.sv
// ============================================================================
// tb_gate_stream_sequencer : directed self-checking bench for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gate_stream_sequencer;
  import qcm_gate_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate_valid;
  logic        gate_ready;
  logic [6:0]  gate_data;
  logic        ld_gate_info;
  logic        done_readout;
  logic        start;
  logic [1:0]  gate_type;
  logic [1:0]  qubit_pos1;
  logic [1:0]  qubit_pos2;
  logic        gate_end;
  logic        literal_phase_readout;
  logic        busy;
  logic        circuit_done;
  logic        underrun_err;
  logic [15:0] gates_issued;

  int n_assert = 0;
  int n_fail   = 0;

  gate_stream_sequencer #(.num_qubit(4), .FIFO_DEPTH(16)) u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .gate_valid            (gate_valid),
    .gate_ready            (gate_ready),
    .gate_data             (gate_data),
    .ld_gate_info          (ld_gate_info),
    .done_readout          (done_readout),
    .start                 (start),
    .gate_type             (gate_type),
    .qubit_pos1            (qubit_pos1),
    .qubit_pos2            (qubit_pos2),
    .gate_end              (gate_end),
    .literal_phase_readout (literal_phase_readout),
    .busy                  (busy),
    .circuit_done          (circuit_done),
    .underrun_err          (underrun_err),
    .gates_issued          (gates_issued)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input logic l, input logic [1:0] t,
                                    input logic [1:0] a, input logic [1:0] b);
    return {l, t, a, b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] d);
    gate_valid = 1'b1;
    gate_data  = d;
    cyc();
    gate_valid = 1'b0;
    gate_data  = '0;
  endtask

  // One control-unit load: check the descriptor presented in this cycle
  task automatic load(input string tag, input logic [5:0] exp_desc, input logic exp_end);
    ld_gate_info = 1'b1;
    #1;
    chk({tag, "_desc"}, {10'd0, gate_type, qubit_pos1, qubit_pos2}, {10'd0, exp_desc});
    chk({tag, "_end"}, {15'd0, gate_end}, {15'd0, exp_end});
    cyc();
    ld_gate_info = 1'b0;
  endtask

  task automatic finish_readout(input string tag);
    done_readout = 1'b1;
    cyc();
    done_readout = 1'b0;
    chk({tag, "_cdone"}, {15'd0, circuit_done}, 16'd1);
    chk({tag, "_lpr_off"}, {15'd0, literal_phase_readout}, 16'd0);
    chk({tag, "_busy_off"}, {15'd0, busy}, 16'd0);
    cyc();
    chk({tag, "_cdone_pulse"}, {15'd0, circuit_done}, 16'd0);
  endtask

  initial begin
    rst          = 1'b1;
    gate_valid   = 1'b0;
    gate_data    = '0;
    ld_gate_info = 1'b0;
    done_readout = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", {15'd0, gate_ready}, 16'd1);
    chk("rst_start", {15'd0, start}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_end", {15'd0, gate_end}, 16'd0);
    chk("rst_lpr", {15'd0, literal_phase_readout}, 16'd0);
    chk("rst_desc", {10'd0, gate_type, qubit_pos1, qubit_pos2}, 16'd0);
    chk("rst_issued", gates_issued, 16'd0);
    chk("rst_underrun", {15'd0, underrun_err}, 16'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Circuit of three gates, loads spaced six cycles apart
    push(mk(1'b0, GT_H, 2'd0, 2'd0));
    push(mk(1'b0, GT_CNOT, 2'd0, 2'd1));
    push(mk(1'b1, GT_MEAS, 2'd2, 2'd0));
    chk("t1_start_early", {15'd0, start}, 16'd0);
    cyc();
    chk("t1_start", {15'd0, start}, 16'd1);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    cyc();
    chk("t1_start_pulse", {15'd0, start}, 16'd0);
    repeat (4) cyc();
    load("t1_h", {GT_H, 2'd0, 2'd0}, 1'b0);
    repeat (5) cyc();
    load("t1_cnot", {GT_CNOT, 2'd0, 2'd1}, 1'b0);
    repeat (5) cyc();
    load("t1_meas", {GT_MEAS, 2'd2, 2'd0}, 1'b0);
    repeat (5) cyc();
    load("t1_endg", 6'd0, 1'b1);
    chk("t1_lpr", {15'd0, literal_phase_readout}, 16'd1);
    chk("t1_ro_end", {15'd0, gate_end}, 16'd1);
    repeat (3) cyc();
    chk("t1_lpr_hold", {15'd0, literal_phase_readout}, 16'd1);
    chk("t1_underrun", {15'd0, underrun_err}, 16'd0);
    finish_readout("t1");
    chk("t1_issued", gates_issued, 16'd3);

    // Fill to full without a last flag, then drain into an underrun
    for (int i = 0; i < 16; i++) push({1'b0, 6'(16 + i)});
    chk("t2_full_ready", {15'd0, gate_ready}, 16'd0);
    chk("t2_start_early", {15'd0, start}, 16'd0);
    cyc();
    chk("t2_start", {15'd0, start}, 16'd1);
    ld_gate_info = 1'b1;
    gate_valid   = 1'b1;
    gate_data    = {1'b0, 6'h3F};
    #1;
    chk("t2_ready_pop", {15'd0, gate_ready}, 16'd0);
    chk("t2_head0", {10'd0, gate_type, qubit_pos1, qubit_pos2}, 16'd16);
    cyc();
    ld_gate_info = 1'b0;
    gate_valid   = 1'b0;
    gate_data    = '0;
    chk("t2_ready_back", {15'd0, gate_ready}, 16'd1);
    for (int i = 1; i < 16; i++) load("t2_pop", 6'(16 + i), 1'b0);
    load("t2_underrun_end", 6'd0, 1'b1);
    chk("t2_underrun", {15'd0, underrun_err}, 16'd1);
    chk("t2_lpr", {15'd0, literal_phase_readout}, 16'd1);
    chk("t2_issued", gates_issued, 16'd16);
    finish_readout("t2");
    chk("t2_underrun_sticky", {15'd0, underrun_err}, 16'd1);

    // Single-gate circuit: second load yields END without underrun
    push(mk(1'b1, GT_S, 2'd3, 2'd1));
    cyc();
    chk("t3_start", {15'd0, start}, 16'd1);
    chk("t3_underrun_clr", {15'd0, underrun_err}, 16'd0);
    load("t3_s", {GT_S, 2'd3, 2'd1}, 1'b0);
    load("t3_endg", 6'd0, 1'b1);
    chk("t3_no_underrun", {15'd0, underrun_err}, 16'd0);
    chk("t3_issued", gates_issued, 16'd1);
    finish_readout("t3");

    // Circuit B buffered during A's readout starts right after A completes
    push(mk(1'b1, GT_CNOT, 2'd1, 2'd2));
    cyc();
    chk("t4_a_start", {15'd0, start}, 16'd1);
    load("t4_a", {GT_CNOT, 2'd1, 2'd2}, 1'b0);
    load("t4_a_end", 6'd0, 1'b1);
    push(mk(1'b0, GT_H, 2'd3, 2'd2));
    push(mk(1'b1, GT_MEAS, 2'd1, 2'd3));
    chk("t4_lpr", {15'd0, literal_phase_readout}, 16'd1);
    load("t4_ro_ld", {GT_H, 2'd3, 2'd2}, 1'b1);
    chk("t4_ro_nopop", {10'd0, gate_type, qubit_pos1, qubit_pos2}, {10'd0, GT_H, 2'd3, 2'd2});
    chk("t4_a_issued", gates_issued, 16'd1);
    done_readout = 1'b1;
    cyc();
    done_readout = 1'b0;
    chk("t4_a_cdone", {15'd0, circuit_done}, 16'd1);
    chk("t4_b_start_early", {15'd0, start}, 16'd0);
    cyc();
    chk("t4_b_start", {15'd0, start}, 16'd1);
    chk("t4_b_cdone_off", {15'd0, circuit_done}, 16'd0);
    chk("t4_b_issued_clr", gates_issued, 16'd0);
    load("t4_b1", {GT_H, 2'd3, 2'd2}, 1'b0);
    load("t4_b2", {GT_MEAS, 2'd1, 2'd3}, 1'b0);
    load("t4_b_end", 6'd0, 1'b1);
    chk("t4_b_issued", gates_issued, 16'd2);
    finish_readout("t4");

    // Concurrent push and pop at depth 7 across the pointer wrap
    for (int i = 0; i < 16; i++) push({1'b0, 6'(32 + i)});
    cyc();
    chk("t6_start", {15'd0, start}, 16'd1);
    for (int i = 0; i < 9; i++) load("t6_pre", 6'(32 + i), 1'b0);
    chk("t6_count_pre", {11'd0, u_dut.u_fifo.count}, 16'd7);
    for (int k = 0; k < 10; k++) begin
      gate_valid   = 1'b1;
      gate_data    = {(k == 9), 6'(48 + k)};
      ld_gate_info = 1'b1;
      #1;
      chk("t6_pp_head", {10'd0, gate_type, qubit_pos1, qubit_pos2}, 16'(41 + k));
      cyc();
      ld_gate_info = 1'b0;
      gate_valid   = 1'b0;
      gate_data    = '0;
      chk("t6_pp_count", {11'd0, u_dut.u_fifo.count}, 16'd7);
    end
    for (int i = 0; i < 7; i++) load("t6_drain", 6'(51 + i), 1'b0);
    load("t6_end", 6'd0, 1'b1);
    chk("t6_issued", gates_issued, 16'd26);
    chk("t6_underrun", {15'd0, underrun_err}, 16'd0);
    finish_readout("t6");

    // Asynchronous reset mid-RUN with five entries queued
    for (int i = 0; i < 6; i++) push({(i == 5), GT_CNOT, 2'(i), 2'd1});
    cyc();
    chk("t5_start", {15'd0, start}, 16'd1);
    load("t5_pop", {GT_CNOT, 2'd0, 2'd1}, 1'b0);
    chk("t5_issued_pre", gates_issued, 16'd1);
    #3 rst = 1'b0;
    #1;
    chk("t5_busy", {15'd0, busy}, 16'd0);
    chk("t5_ready", {15'd0, gate_ready}, 16'd1);
    chk("t5_desc", {10'd0, gate_type, qubit_pos1, qubit_pos2}, 16'd0);
    chk("t5_issued", gates_issued, 16'd0);
    chk("t5_end", {15'd0, gate_end}, 16'd0);
    chk("t5_lpr", {15'd0, literal_phase_readout}, 16'd0);
    repeat (2) cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_post_start", {15'd0, start}, 16'd0);
      chk("t5_post_busy", {15'd0, busy}, 16'd0);
      chk("t5_post_cdone", {15'd0, circuit_done}, 16'd0);
    end
    chk("t5_post_count", {11'd0, u_dut.u_fifo.count}, 16'd0);
    chk("t5_post_desc", {10'd0, gate_type, qubit_pos1, qubit_pos2}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
